xbar_aw_route_tracker: RTL
==========================

// Module: xbar_aw_route_tracker
// PURPOSE
// Per-master write-address routing stage for the AXI crossbar.
// - Decodes each AW address into a subordinate index over a linear, power-of-two region map.
// - Sends unmapped addresses to an error-slave index, NUM_SLV.
// - Tracks outstanding writes per ID and keeps same-ID writes on a single destination
//   until they retire, which preserves AXI ordering.
// - Caps total outstanding writes at MAX_TRANS.
// - Sits between a master port and the AW demux; one instance per master.
// PARAMETERS
// NUM_SLV      4             number of mapped subordinates; sel index NUM_SLV = decode error
// ADDR_W       32            AW address width
// ID_W         4             AW/B ID width (2**ID_W tracker entries)
// MAX_TRANS    8             max outstanding writes, total and per ID
// BASE_ADDR    32'h2000_0000 start of subordinate 0 region
// REGION_SIZE  32'h1000_0000 bytes per subordinate; power of two, >0
// SEL_W        $clog2(NUM_SLV+1) width of select (derived, localparam)
// CNT_W        $clog2(MAX_TRANS+1) width of counters (derived, localparam)
// PORTS
// clk_i            in   1       clock, all logic rising-edge
// rst_i            in   1       asynchronous reset, active-high
// slv_aw_valid_i   in   1       incoming AW valid
// slv_aw_ready_o   out  1       incoming AW ready
// slv_aw_addr_i    in   ADDR_W  incoming AW address
// slv_aw_id_i      in   ID_W    incoming AW ID
// mst_aw_valid_o   out  1       routed AW valid
// mst_aw_ready_i   in   1       routed AW ready from demux
// mst_aw_addr_o    out  ADDR_W  registered address
// mst_aw_id_o      out  ID_W    registered ID
// mst_aw_sel_o     out  SEL_W   registered destination index
// mst_aw_decerr_o  out  1       registered: address unmapped (sel==NUM_SLV)
// b_valid_i        in   1       B channel valid (monitored)
// b_ready_i        in   1       B channel ready (monitored)
// b_id_i           in   ID_W    B channel ID
// outstanding_o    out  CNT_W   total outstanding writes
// b_orphan_o       out  1       1-cycle pulse: B handshake for an ID whose count is 0
// BEHAVIOUR
// - Reset: rst_i=1 asynchronously clears all outputs to 0, every id_cnt to 0, and the pipeline slot.
//   Reset mid-operation drops any held AW; nothing is replayed afterwards.
// - Decode (combinational, ADDR_W+1-bit arithmetic, so the end bound cannot overflow):
//   - hit if BASE_ADDR <= addr < BASE_ADDR + NUM_SLV*REGION_SIZE;
//   - on hit, sel = (addr - BASE_ADDR) >> log2(REGION_SIZE);
//   - on miss, sel = NUM_SLV and decerr = 1.
// - One register slot with latency 1: an AW accepted in cycle N appears on mst_aw_* in cycle N+1.
// - Slot rules:
//   - mst_aw_* stays stable while mst_aw_valid_o=1 && mst_aw_ready_i=0;
//   - the slot frees in the same cycle the output handshake completes, giving 1 AW/cycle at full rate.
// - slv_aw_ready_o = slot_free && total<MAX_TRANS && id_ok, where:
//   - slot_free = !mst_aw_valid_o || mst_aw_ready_i;
//   - id_ok = (id_cnt[id]==0) || (id_dest[id]==sel && id_cnt[id]<MAX_TRANS).
//   - Ready depends combinationally on the presented addr/id. A master never withdraws valid
//     while ready is low.
// - Accept (slv handshake): id_cnt[id]++, id_dest[id]<=sel, total++.
// - Retire (b_valid_i && b_ready_i):
//   - if id_cnt[b_id]>0: id_cnt[b_id]--, total--;
//   - else the event is ignored and b_orphan_o pulses for 1 cycle.
// - Simultaneous accept and retire:
//   - same ID: id_cnt and total are unchanged, and id_dest is updated;
//   - different IDs: each applies independently and total is unchanged.
// - Retire frees capacity one cycle later; there is no combinational B->ready path.
// - The decode-error index is counted and ordered like any other destination.
// - No state machine beyond the slot valid bit and the counters. Counters saturate and never wrap.
// TESTING
// 1. Accept 0x2000_0000, 0x5FFF_FFFC, 0x6000_0000, 0x1FFF_FFFF, one per cycle ->
//    next-cycle sel 0, 3, 4, 4 and decerr 0, 0, 1, 1.
// 2. id=2 to 0x3000_0000 outstanding, then id=2 to 0x4000_0000 -> ready=0 until B id=2 retires;
//    accepted the following cycle with sel=2.
// 3. 8 AWs with no B -> outstanding_o=8 and the 9th AW sees ready=0;
//    one B handshake -> 9th accepted 1 cycle later.
// 4. Accept id=5 in the same cycle as B id=5 with id_cnt[5]=1 -> id_cnt[5] stays 1, outstanding_o unchanged.
// 5. mst_aw_ready_i=0 for 3 cycles with a held AW -> mst_aw_* stable and slv_aw_ready_o=0;
//    release -> back-to-back 1/cycle. B id=7 with count 0 -> b_orphan_o pulses, counts unchanged.
// 6. Assert rst_i asynchronously mid-stream with 3 outstanding -> all outputs 0 before the next edge;
//    after release, outstanding_o=0 and the first AW is accepted normally.

Source files
------------

// File: rtl/xbar_aw_route_tracker.sv
// Per-master AW routing stage: decodes the destination, holds one AW in a register slot and
// tracks outstanding writes per ID so same-ID writes never split across destinations.
module xbar_aw_route_tracker #(
    parameter int unsigned       NUM_SLV     = 4,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       ID_W        = 4,
    parameter int unsigned       MAX_TRANS   = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h1000_0000,
    localparam int unsigned      SEL_W       = $clog2(NUM_SLV + 1),
    localparam int unsigned      CNT_W       = $clog2(MAX_TRANS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slv_aw_valid_i,
    output logic              slv_aw_ready_o,
    input  logic [ADDR_W-1:0] slv_aw_addr_i,
    input  logic [ID_W-1:0]   slv_aw_id_i,
    output logic              mst_aw_valid_o,
    input  logic              mst_aw_ready_i,
    output logic [ADDR_W-1:0] mst_aw_addr_o,
    output logic [ID_W-1:0]   mst_aw_id_o,
    output logic [SEL_W-1:0]  mst_aw_sel_o,
    output logic              mst_aw_decerr_o,
    input  logic              b_valid_i,
    input  logic              b_ready_i,
    input  logic [ID_W-1:0]   b_id_i,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              b_orphan_o
);

    localparam int unsigned      EXT_W        = ADDR_W + 1;
    localparam int unsigned      NUM_IDS      = 2 ** ID_W;
    localparam int unsigned      REGION_SHIFT = $clog2(REGION_SIZE);
    localparam logic [EXT_W-1:0] BaseExt      = {1'b0, BASE_ADDR};
    localparam logic [EXT_W-1:0] EndExt       = BaseExt + EXT_W'(NUM_SLV) * {1'b0, REGION_SIZE};
    localparam logic [SEL_W-1:0] ErrSel       = SEL_W'(NUM_SLV);
    localparam logic [CNT_W-1:0] MaxCnt       = CNT_W'(MAX_TRANS);

    // Address decode, one bit wider than the address so the region end cannot wrap.
    logic [EXT_W-1:0] addr_ext;
    logic [EXT_W-1:0] offset;
    logic             hit;
    logic [SEL_W-1:0] dec_sel;

    always_comb begin
        addr_ext = {1'b0, slv_aw_addr_i};
        hit      = (addr_ext >= BaseExt) && (addr_ext < EndExt);
        offset   = addr_ext - BaseExt;
        dec_sel  = hit ? SEL_W'(offset >> REGION_SHIFT) : ErrSel;
    end

    logic              slot_valid_q;
    logic [ADDR_W-1:0] slot_addr_q;
    logic [ID_W-1:0]   slot_id_q;
    logic [SEL_W-1:0]  slot_sel_q;
    logic              slot_decerr_q;

    logic [CNT_W-1:0]  id_cnt_q  [NUM_IDS];
    logic [CNT_W-1:0]  id_cnt_d  [NUM_IDS];
    logic [SEL_W-1:0]  id_dest_q [NUM_IDS];
    logic [SEL_W-1:0]  id_dest_d [NUM_IDS];
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  total_d;
    logic              orphan_q;
    logic              orphan_d;

    logic              slot_free;
    logic [CNT_W-1:0]  cur_cnt;
    logic              id_ok;
    logic              aw_ready;
    logic              accept;
    logic              b_fire;
    logic              retire;
    logic [NUM_IDS-1:0] inc_vec;
    logic [NUM_IDS-1:0] dec_vec;

    always_comb begin
        slot_free = !slot_valid_q || mst_aw_ready_i;
        cur_cnt   = id_cnt_q[slv_aw_id_i];
        id_ok     = (cur_cnt == '0) ||
                    ((id_dest_q[slv_aw_id_i] == dec_sel) && (cur_cnt < MaxCnt));
        // Gated by reset so every output reads 0 while reset is held.
        aw_ready  = !rst_i && slot_free && (total_q < MaxCnt) && id_ok;
        accept    = slv_aw_valid_i && aw_ready;
        b_fire    = b_valid_i && b_ready_i;
        retire    = b_fire && (id_cnt_q[b_id_i] != '0);
        orphan_d  = b_fire && !retire;
        inc_vec   = NUM_IDS'(accept) << slv_aw_id_i;
        dec_vec   = NUM_IDS'(retire) << b_id_i;
    end

    // Same-ID accept and retire cancel; the destination still follows the new accept.
    always_comb begin
        id_cnt_d  = id_cnt_q;
        id_dest_d = id_dest_q;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (inc_vec[i] && !dec_vec[i] && (id_cnt_q[i] != MaxCnt)) begin
                id_cnt_d[i] = id_cnt_q[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                id_cnt_d[i] = id_cnt_q[i] - 1'b1;
            end
            if (inc_vec[i]) begin
                id_dest_d[i] = dec_sel;
            end
        end
    end

    always_comb begin
        total_d = total_q;
        if (accept && !retire && (total_q != MaxCnt)) begin
            total_d = total_q + 1'b1;
        end else if (retire && !accept && (total_q != '0)) begin
            total_d = total_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q  <= 1'b0;
            slot_addr_q   <= '0;
            slot_id_q     <= '0;
            slot_sel_q    <= '0;
            slot_decerr_q <= 1'b0;
            total_q       <= '0;
            orphan_q      <= 1'b0;
            for (int i = 0; i < NUM_IDS; i++) begin
                id_cnt_q[i]  <= '0;
                id_dest_q[i] <= '0;
            end
        end else begin
            if (slot_free) begin
                slot_valid_q <= accept;
                if (accept) begin
                    slot_addr_q   <= slv_aw_addr_i;
                    slot_id_q     <= slv_aw_id_i;
                    slot_sel_q    <= dec_sel;
                    slot_decerr_q <= !hit;
                end
            end
            total_q   <= total_d;
            orphan_q  <= orphan_d;
            id_cnt_q  <= id_cnt_d;
            id_dest_q <= id_dest_d;
        end
    end

    assign slv_aw_ready_o  = aw_ready;
    assign mst_aw_valid_o  = slot_valid_q;
    assign mst_aw_addr_o   = slot_addr_q;
    assign mst_aw_id_o     = slot_id_q;
    assign mst_aw_sel_o    = slot_sel_q;
    assign mst_aw_decerr_o = slot_decerr_q;
    assign outstanding_o   = total_q;
    assign b_orphan_o      = orphan_q;

endmodule
